// File: rtl/argmax_pkg.sv
// argmax_pkg: shared types and helpers for the argmax_sequencer block.
//   state_e   : frame controller states (IDLE, ACCUM, DONE)
//   idx_width : channel-index width for a given channel count (never below 1)
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argmax_sequencer_bias_regfile.sv
// bias_regfile: one bias register per output channel.
//   clk, rst : clock, synchronous active-high clear of every entry
//   we, waddr, wdata : synchronous write port (out-of-range addresses dropped)
//   raddr, rdata     : combinational read port
module bias_regfile #(
  parameter int DATA_WIDTH     = 8,
  parameter int OUTPUT_CHANNEL = 10,
  parameter int IDX_W          = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [IDX_W:0] NCH = (IDX_W+1)'(OUTPUT_CHANNEL);

  logic [DATA_WIDTH-1:0] mem_q [OUTPUT_CHANNEL];
  logic                  waddr_ok_s;
  logic                  raddr_ok_s;

  assign waddr_ok_s = ({1'b0, waddr} < NCH);
  assign raddr_ok_s = ({1'b0, raddr} < NCH);

  // Bias storage: clear on reset, otherwise accept in-range writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUTPUT_CHANNEL; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && waddr_ok_s) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port; an out-of-range index reads as zero instead of indexing past the array.
  always_comb begin
    rdata = '0;
    if (raddr_ok_s) begin
      rdata = mem_q[raddr];
    end else begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/argmax_sequencer.sv
// argmax_sequencer: streams one frame of OUTPUT_CHANNEL class scores, adds the
// per-channel bias, and reports the channel with the largest biased score.
//   clk, rst                           : clock, synchronous active-high reset
//   start                              : begin a frame (IDLE only)
//   bias_we, bias_addr, bias_wdata     : bias write port (IDLE only)
//   in_valid, in_ready, in_score       : score stream, channels in order 0..N-1
//   out_valid, out_ready               : result handshake
//   number, max_score                  : winning channel and its biased score
//   busy                               : high whenever not IDLE
module argmax_sequencer
  import argmax_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int OUTPUT_CHANNEL = 10,
  parameter int IDX_W          = idx_width(OUTPUT_CHANNEL)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  bias_we,
  input  logic [IDX_W-1:0]      bias_addr,
  input  logic [DATA_WIDTH-1:0] bias_wdata,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_score,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      number,
  output logic [DATA_WIDTH:0]   max_score,
  output logic                  busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_CHANNEL - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   run_max_q, run_max_d;
  logic [IDX_W-1:0]      run_idx_q, run_idx_d;
  logic [IDX_W-1:0]      number_q, number_d;
  logic [DATA_WIDTH:0]   max_score_q, max_score_d;

  logic [DATA_WIDTH-1:0] bias_rd_s;
  logic [DATA_WIDTH:0]   sum_s;
  logic                  take_s;
  logic [DATA_WIDTH:0]   new_max_s;
  logic [IDX_W-1:0]      new_idx_s;

  bias_regfile #(
    .DATA_WIDTH     (DATA_WIDTH),
    .OUTPUT_CHANNEL (OUTPUT_CHANNEL),
    .IDX_W          (IDX_W)
  ) u_bias (
    .clk   (clk),
    .rst   (rst),
    .we    (bias_we && (state_q == IDLE)),
    .waddr (bias_addr),
    .wdata (bias_wdata),
    .raddr (cnt_q),
    .rdata (bias_rd_s)
  );

  // One extra bit keeps score + bias from wrapping. Strict '>' keeps the
  // earlier (lower) index on ties; channel 0 always seeds the running max.
  assign sum_s     = {1'b0, in_score} + {1'b0, bias_rd_s};
  assign take_s    = (cnt_q == '0) || (sum_s > run_max_q);
  assign new_max_s = take_s ? sum_s : run_max_q;
  assign new_idx_s = take_s ? cnt_q : run_idx_q;

  // Next-state logic for the frame FSM, counter, running max and result.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    number_d    = number_q;
    max_score_d = max_score_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCUM;
          cnt_d     = '0;
          run_max_d = '0;
          run_idx_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          run_max_d = new_max_s;
          run_idx_d = new_idx_s;
          if (cnt_q == LAST_IDX) begin
            // Result includes this final beat's own comparison.
            state_d     = DONE;
            cnt_d       = '0;
            number_d    = new_idx_s;
            max_score_d = new_max_s;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      number_q    <= '0;
      max_score_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      number_q    <= number_d;
      max_score_q <= max_score_d;
    end
  end

  // Handshake outputs decode only the state register.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign number    = number_q;
  assign max_score = max_score_q;

endmodule

// File: tb/tb_argmax_sequencer.sv
module tb_argmax_sequencer;

  localparam int DW  = 8;
  localparam int NCH = 10;
  localparam int IW  = 4;

  typedef int arr_t [NCH];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          bias_we = 1'b0;
  logic [IW-1:0] bias_addr = '0;
  logic [DW-1:0] bias_wdata = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_score = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] number;
  logic [DW:0]   max_score;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  argmax_sequencer #(.DATA_WIDTH(DW), .OUTPUT_CHANNEL(NCH)) dut (
    .clk(clk), .rst(rst), .start(start), .bias_we(bias_we),
    .bias_addr(bias_addr), .bias_wdata(bias_wdata), .in_valid(in_valid),
    .in_ready(in_ready), .in_score(in_score), .out_valid(out_valid),
    .out_ready(out_ready), .number(number), .max_score(max_score), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = idle, 1 = collecting scores, 2 = result presented
  int   m_phase = 0;
  int   m_cnt = 0;
  arr_t m_scores;
  arr_t m_bias;
  int   m_number = 0;
  int   m_max = 0;

  // Argmax over biased scores; the score of channel last_i is taken from last_v.
  // Returns idx*1024 + max.
  function automatic int best(input arr_t s, input arr_t b, input int last_i, input int last_v);
    int bi = 0;
    int bv = -1;
    for (int i = 0; i < NCH; i++) begin
      int v = ((i == last_i) ? last_v : s[i]) + b[i];
      if (v > bv) begin
        bv = v;
        bi = i;
      end
    end
    return bi * 1024 + bv;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase  <= 0;
      m_cnt    <= 0;
      m_number <= 0;
      m_max    <= 0;
      for (int i = 0; i < NCH; i++) m_bias[i] <= 0;
    end else begin
      case (m_phase)
        0: begin
          if (bias_we && bias_addr < NCH) m_bias[bias_addr] <= int'(bias_wdata);
          if (start) begin
            m_phase <= 1;
            m_cnt   <= 0;
          end
        end
        1: begin
          if (in_valid) begin
            m_scores[m_cnt] <= int'(in_score);
            m_cnt <= m_cnt + 1;
            if (m_cnt == NCH - 1) begin
              m_phase  <= 2;
              m_number <= best(m_scores, m_bias, m_cnt, int'(in_score)) / 1024;
              m_max    <= best(m_scores, m_bias, m_cnt, int'(in_score)) % 1024;
            end
          end
        end
        default: begin
          if (out_ready) m_phase <= 0;
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  int'(in_ready),  int'(m_phase == 1));
      check("out_valid", int'(out_valid), int'(m_phase == 2));
      check("busy",      int'(busy),      int'(m_phase != 0));
      check("number",    int'(number),    m_number);
      check("max_score", int'(max_score), m_max);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input arr_t s, input int gap, input int hold, input int exp_idx,
                           input int exp_max, input int exp_lat, input bit poke, input string tag);
    int c0;
    int n;
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    bias_we = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        if (poke && ch == 2 && g == 0) begin
          // Ignored while busy: would make ch0 win if honoured.
          bias_we = 1'b1; bias_addr = 4'd0; bias_wdata = 8'd200; start = 1'b1;
        end
        tick();
        bias_we = 1'b0;
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_score = DW'(s[ch]);
      tick();
      in_valid = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      check({tag, " out_valid timeout"}, 0, 1);
    end else begin
      if (exp_lat >= 0) check({tag, " latency"}, cyc - c0, exp_lat);
      check({tag, " number"}, int'(number), exp_idx);
      check({tag, " max_score"}, int'(max_score), exp_max);
      check({tag, " model number"}, m_number, exp_idx);
      check({tag, " model max"}, m_max, exp_max);
      for (int h = 0; h < hold; h++) begin
        tick();
        check({tag, " held out_valid"}, int'(out_valid), 1);
        check({tag, " held number"}, int'(number), exp_idx);
        check({tag, " held max_score"}, int'(max_score), exp_max);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " out_valid after accept"}, int'(out_valid), 0);
      check({tag, " busy after accept"}, int'(busy), 0);
      check({tag, " number retained"}, int'(number), exp_idx);
    end
  endtask

  arr_t s;

  initial begin
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("reset in_ready", int'(in_ready), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset number", int'(number), 0);
    check("reset max_score", int'(max_score), 0);
    check("reset busy", int'(busy), 0);
    tick();

    // Ascending scores, zero bias.
    for (int i = 0; i < NCH; i++) s[i] = i;
    run_frame(s, 0, 0, 9, 9, 11, 1'b0, "ramp");
    tick();

    // All equal: lowest index wins.
    for (int i = 0; i < NCH; i++) s[i] = 5;
    run_frame(s, 0, 0, 0, 5, 11, 1'b0, "tie");
    tick();

    // Gaps of 2, ignored bias write and start during ACCUM, 3-cycle out_ready stall.
    s = '{3, 9, 2, 9, 1, 0, 4, 8, 7, 6};
    run_frame(s, 2, 3, 1, 9, -1, 1'b1, "backpressure");
    tick();

    // Overflow: out-of-range write ignored, bias[3] written in the start cycle.
    bias_we = 1'b1; bias_addr = 4'd12; bias_wdata = 8'd50;
    tick();
    bias_we = 1'b1; bias_addr = 4'd3; bias_wdata = 8'd100;
    for (int i = 0; i < NCH; i++) s[i] = 250;
    s[3] = 200;
    run_frame(s, 0, 0, 3, 300, 11, 1'b0, "overflow");
    tick();

    // Reset mid-frame after 4 beats.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      in_valid = 1'b1;
      in_score = 8'd90;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("midrst in_ready", int'(in_ready), 0);
    check("midrst out_valid", int'(out_valid), 0);
    check("midrst number", int'(number), 0);
    check("midrst max_score", int'(max_score), 0);
    check("midrst busy", int'(busy), 0);
    tick();

    // Fresh frame after reset; bias[3] must be cleared.
    for (int i = 0; i < NCH; i++) s[i] = 1;
    s[6] = 7;
    run_frame(s, 0, 0, 6, 7, 11, 1'b0, "postrst");
    tick();
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
